// File: rtl/regfile_param.sv
// Two-write / two-read register file with a background clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_param #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in1_we,
  input  logic [ADDR_BITS-1:0] in1_sel,
  input  logic [WIDTH-1:0]     in1_data,
  input  logic                 in2_we,
  input  logic [ADDR_BITS-1:0] in2_sel,
  input  logic [WIDTH-1:0]     in2_data,
  input  logic [ADDR_BITS-1:0] out1_sel,
  output logic [WIDTH-1:0]     out1_data,
  input  logic [ADDR_BITS-1:0] out2_sel,
  output logic [WIDTH-1:0]     out2_data,
  input  logic                 clr_req,
  output logic                 clr_busy
);

  localparam int unsigned          DEPTH   = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LastIdx = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic [WIDTH-1:0]     regs_d [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        // Counter wraps to zero on its own as the last address is swept.
        cnt_d = cnt_q + ADDR_BITS'(1);
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_busy = (state_q == StSweep);

  // Later assignments take priority: sweep < port 1 < port 2.
  always_comb begin
    regs_d = regs_q;
    if (state_q == StSweep) begin
      regs_d[cnt_q] = '0;
    end
    if (in1_we) begin
      regs_d[in1_sel] = in1_data;
    end
    if (in2_we) begin
      regs_d[in2_sel] = in2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // regs_d already folds in this cycle's sweep and port writes.
  always_comb begin
    out1_data = rst ? regs_q[out1_sel] : regs_d[out1_sel];
    out2_data = rst ? regs_q[out2_sel] : regs_d[out2_sel];
  end
`else
  always_comb begin
    out1_data = regs_q[out1_sel];
    out2_data = regs_q[out2_sel];
  end
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_regfile_param;

  localparam int W  = 16;
  localparam int AB = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in1_we, in2_we, clr_req;
  logic [AB-1:0] in1_sel, in2_sel, out1_sel, out2_sel;
  logic [W-1:0]  in1_data, in2_data;
  logic [W-1:0]  out1_data, out2_data;
  logic          clr_busy;

  always #50 clk = ~clk;

  regfile_param #(
    .WIDTH    (W),
    .ADDR_BITS(AB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in1_we   (in1_we),
    .in1_sel  (in1_sel),
    .in1_data (in1_data),
    .in2_we   (in2_we),
    .in2_sel  (in2_sel),
    .in2_data (in2_data),
    .out1_sel (out1_sel),
    .out1_data(out1_data),
    .out2_sel (out2_sel),
    .out2_data(out2_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus sweep progress.
  logic [W-1:0] mem [D];
  bit           busy_m;
  int           idx_m;

  function automatic logic [W-1:0] peek(input logic [AB-1:0] sel);
    logic [W-1:0] v;
    v = mem[sel];
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      if (busy_m && idx_m == int'(sel)) v = '0;
      if (in1_we && in1_sel == sel) v = in1_data;
      if (in2_we && in2_sel == sel) v = in2_data;
    end
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      foreach (mem[i]) mem[i] = '0;
      busy_m = 1'b0;
      idx_m  = 0;
    end else begin
      if (busy_m) begin
        mem[idx_m] = '0;
        idx_m++;
        if (idx_m == D) begin
          busy_m = 1'b0;
          idx_m  = 0;
        end
      end else if (clr_req) begin
        busy_m = 1'b1;
        idx_m  = 0;
      end
      if (in1_we) mem[in1_sel] = in1_data;
      if (in2_we) mem[in2_sel] = in2_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("clr_busy", W'(clr_busy), W'(busy_m));
  endtask

  task automatic check_reads(input string tag);
    check({tag, "/out1"}, out1_data, peek(out1_sel));
    check({tag, "/out2"}, out2_data, peek(out2_sel));
  endtask

  task automatic idle_inputs();
    rst      = 1'b0;
    clr_req  = 1'b0;
    in1_we   = 1'b0;
    in1_sel  = '0;
    in1_data = '0;
    in2_we   = 1'b0;
    in2_sel  = '0;
    in2_data = '0;
  endtask

  task automatic wr(input logic we1, input logic [AB-1:0] s1, input logic [W-1:0] d1,
                    input logic we2, input logic [AB-1:0] s2, input logic [W-1:0] d2);
    in1_we   = we1;
    in1_sel  = s1;
    in1_data = d1;
    in2_we   = we2;
    in2_sel  = s2;
    in2_data = d2;
  endtask

  task automatic dump_all(input string tag);
    idle_inputs();
    for (int i = 0; i < D; i++) begin
      out1_sel = AB'(i);
      out2_sel = AB'(D - 1 - i);
      #1;
      check_reads(tag);
    end
  endtask

  int busy_cnt;

  initial begin
    idle_inputs();
    out1_sel = '0;
    out2_sel = '0;
    foreach (mem[i]) mem[i] = 'x;

    // Reset wins over a write and a clear request in the same cycle.
    rst     = 1'b1;
    clr_req = 1'b1;
    wr(1'b1, 4'd5, 16'h1234, 1'b1, 4'd6, 16'h5678);
    tick();
    dump_all("reset");
    out1_sel = 4'd5;
    #1;
    check("reset_r5", out1_data, 16'h0000);

    // Two writes to different addresses in one cycle.
    wr(1'b1, 4'd1, 16'hDEAD, 1'b1, 4'd2, 16'hBEEF);
    out1_sel = 4'd1;
    out2_sel = 4'd2;
    tick();
    check("r1_dead", out1_data, 16'hDEAD);
    check("r2_beef", out2_data, 16'hBEEF);

    // Same-address collision: port 2 wins.
    wr(1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222);
    tick();
    idle_inputs();
    out1_sel = 4'd3;
    #1;
    check("r3_port2_wins", out1_data, 16'h2222);

    // Read-during-write visibility.
    wr(1'b1, 4'd4, 16'hCAFE, 1'b0, 4'd0, 16'h0000);
    out1_sel = 4'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r4_pre_edge", out1_data, 16'hCAFE);
`else
    check("r4_pre_edge", out1_data, 16'h0000);
`endif
    tick();
    idle_inputs();
    #1;
    check("r4_post_edge", out1_data, 16'hCAFE);

    // Full sweep with a port write landing on the address being swept.
    for (int i = 0; i < D; i += 2) begin
      wr(1'b1, AB'(i), W'(16'h00A0 + i), 1'b1, AB'(i + 1), W'(16'h00A0 + i + 1));
      tick();
    end
    dump_all("loaded");
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = clr_busy ? 1 : 0;
    for (int j = 0; j < D; j++) begin
      idle_inputs();
      if (j == 9) wr(1'b1, 4'd9, 16'h5555, 1'b0, 4'd0, 16'h0000);
      if (j == 3) clr_req = 1'b1;
      out1_sel = AB'(j);
      out2_sel = AB'($urandom_range(D - 1));
      #1;
      check_reads("sweep_pre");
      tick();
      if (clr_busy) busy_cnt++;
    end
    check("busy_cycles", W'(busy_cnt), W'(16));
    dump_all("swept");
    out1_sel = 4'd9;
    out2_sel = 4'd0;
    #1;
    check("r9_port_wins", out1_data, 16'h5555);
    check("r0_swept", out2_data, 16'h0000);

    // Reset in the middle of a sweep, then a fresh sweep restarts from r0.
    for (int i = 0; i < D; i += 2) begin
      wr(1'b1, AB'(i), W'(16'h8000 | $urandom_range(16'h7fff)), 1'b1, AB'(i + 1),
         W'(16'h8000 | $urandom_range(16'h7fff)));
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    rst = 1'b1;
    wr(1'b1, 4'd7, 16'hABCD, 1'b1, 4'd12, 16'h4321);
    tick();
    check("rst_mid_sweep_busy", W'(clr_busy), W'(0));
    dump_all("rst_mid_sweep");
    out1_sel = 4'd12;
    #1;
    check("rst_beats_write", out1_data, 16'h0000);
    wr(1'b1, 4'd0, 16'h1234, 1'b1, 4'd1, 16'h5678);
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    out1_sel = 4'd0;
    out2_sel = 4'd1;
    #1;
    check("restart_r0", out1_data, 16'h0000);
    check("restart_r1", out2_data, 16'h5678);
    for (int j = 0; j < 2 * D && busy_m; j++) tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      in1_we = 1'($urandom_range(1));
      in2_we = 1'($urandom_range(1));
      in1_sel = in1_we ? AB'($urandom_range(D - 1)) : 'x;
      in2_sel = in2_we ? AB'($urandom_range(D - 1)) : 'x;
      in1_data = in1_we ? W'($urandom) : 'x;
      in2_data = in2_we ? W'($urandom) : 'x;
      clr_req  = ($urandom_range(15) == 0);
      rst      = ($urandom_range(63) == 0);
      out1_sel = AB'($urandom_range(D - 1));
      out2_sel = AB'($urandom_range(D - 1));
      #1;
      check_reads("rand_pre");
      tick();
      check_reads("rand_post");
    end
    dump_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each register and data port.
REQ-002 Parameter ADDR_BITS, default 4: select width; DEPTH = 2**ADDR_BITS registers.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in1_we  input  1  write enable, write port 1.
REQ-006 in1_sel  input  ADDR_BITS  write address, port 1.
REQ-007 in1_data  input  WIDTH  write data, port 1.
REQ-008 in2_we  input  1  write enable, write port 2.
REQ-009 in2_sel  input  ADDR_BITS  write address, port 2.
REQ-010 in2_data  input  WIDTH  write data, port 2.
REQ-011 out1_sel  input  ADDR_BITS  read address, port 1.
REQ-012 out1_data  output  WIDTH  read data, port 1.
REQ-013 out2_sel  input  ADDR_BITS  read address, port 2.
REQ-014 out2_data  output  WIDTH  read data, port 2.
REQ-015 clr_req  input  1  request bulk clear sweep.
REQ-016 clr_busy  output  1  clear sweep in progress.

Function
REQ-017 Reads SHALL be combinational: outN_data = reg[outN_sel], zero clock latency.
REQ-018 A write with inN_we=1 SHALL update reg[inN_sel] at the next rising clk edge; value visible on reads after that edge.
REQ-019 inN_sel/inN_data SHALL be don't-care (including X) while inN_we=0; no register changes.
REQ-020 Both ports writing the same address in one cycle: port 2 SHALL win; port 1 data discarded.
REQ-021 Both ports writing different addresses in one cycle: both writes SHALL complete in that cycle.
REQ-022 Clear FSM states: IDLE, SWEEP; IDLE on reset.
REQ-023 IDLE with clr_req=1 at an edge: SHALL enter SWEEP, sweep counter = 0; clr_busy=1 from that edge.
REQ-024 SWEEP: each cycle SHALL write zero to reg[counter], then increment counter; exactly DEPTH cycles, clr_busy high for exactly DEPTH cycles.
REQ-025 SWEEP on the cycle counter = DEPTH-1: SHALL return to IDLE at that edge, clr_busy=0; counter wraps to 0 with no extra cycle.
REQ-026 clr_req while in SWEEP SHALL be ignored (no restart, no queueing).
REQ-027 Port write and sweep targeting the same address in the same cycle: port write SHALL win.
REQ-028 Port writes during SWEEP to other addresses SHALL complete normally; addresses not yet swept are later zeroed.

Reset
REQ-029 rst=1 at a rising edge SHALL zero all DEPTH registers, force FSM to IDLE, counter 0, clr_busy 0.
REQ-030 rst SHALL take priority over port writes and sweep in the same cycle, including mid-sweep.
REQ-031 After reset both read ports SHALL return 0 for every address.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN defined: a read whose outN_sel matches an active same-cycle write address SHALL return that write data combinationally (port 2 data if both match); a sweep write on that address returns 0 unless overridden by a port write; rst cycles bypass nothing.
REQ-033 REGFILE_BYPASS_EN undefined: reads SHALL return only stored values; written data visible only after the edge.

Verification
REQ-034 Reset, then in1 writes 0xDEAD to r1 and in2 writes 0xBEEF to r2 in one cycle, read r1/r2 -> out1=dead, out2=beef after the edge.
REQ-035 Both ports write r3 (0x1111 port 1, 0x2222 port 2) same cycle -> r3=2222.
REQ-036 Without REGFILE_BYPASS_EN: write 0xCAFE to r4 while reading r4 -> pre-edge 0000, post-edge cafe; with it -> cafe same cycle.
REQ-037 Load r0..r15 with 0x00A0+i, pulse clr_req -> clr_busy high exactly 16 cycles, then all reads 0000; in1 writes 0x5555 to r9 in the cycle it is swept -> r9=5555.
REQ-038 Start sweep, assert rst at sweep cycle 5 -> next edge clr_busy=0, all registers 0000, second clr_req restarts from r0.
